// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin / fixed-select channel multiplexer.
package rr_mux_arb_pkg;

    typedef enum logic [0:0] {
        MODE_RR  = 1'b0,
        MODE_FIX = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational grant selection: rotating priority from ptr, or a fixed channel.
module rr_grant
    import rr_mux_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    input  logic             fix_en,
    input  logic [SEL_W-1:0] fix_sel,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    logic             hi_found_s;
    logic             lo_found_s;
    logic             fix_hit_s;
    logic             hit_hi_s;
    logic [SEL_W-1:0] hi_idx_s;
    logic [SEL_W-1:0] lo_idx_s;

    // Split the ring at ptr: lowest valid index >= ptr wins, else lowest index below ptr.
    // Only indices below N_CH are scanned, so a non-power-of-two ring never grants a ghost channel.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        fix_hit_s  = 1'b0;
        hit_hi_s   = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            hit_hi_s   = valid[i] & (SEL_W'(i) >= ptr);
            hi_found_s = hi_found_s | hit_hi_s;
            hi_idx_s   = hit_hi_s ? SEL_W'(i) : hi_idx_s;
            lo_found_s = lo_found_s | (valid[i] & ~hit_hi_s);
            lo_idx_s   = (valid[i] & ~hit_hi_s) ? SEL_W'(i) : lo_idx_s;
            fix_hit_s  = fix_hit_s | (valid[i] & (fix_sel == SEL_W'(i)));
        end
    end

    // Mode select between the rotating search and the legacy fixed select.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        case (mode_e'(fix_en))
            MODE_RR: begin
                grant_valid = hi_found_s | lo_found_s;
                grant_idx   = hi_found_s ? hi_idx_s : lo_idx_s;
            end
            MODE_FIX: begin
                grant_valid = fix_hit_s;
                grant_idx   = fix_sel;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready multiplexer with round-robin or fixed select and a
// single registered output stage that refills on the same edge it drains.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 4,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     fix_en,
    input  logic [SEL_W-1:0]         fix_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic              load_s;
    logic              fire_s;
    logic              grant_valid_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic [SEL_W-1:0]  ptr_r;
    logic [SEL_W-1:0]  ptr_nxt_s;
    logic [SEL_W-1:0]  ch_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] sel_data_s;
    logic              valid_r;

    rr_grant #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_grant (
        .valid       (in_valid),
        .ptr         (ptr_r),
        .fix_en      (fix_en),
        .fix_sel     (fix_sel),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    assign load_s = ~valid_r | out_ready;
    assign fire_s = load_s & grant_valid_s;

    // Ready goes only to the granted channel; the same index steers the data mux.
    always_comb begin
        in_ready   = '0;
        sel_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = fire_s & (grant_idx_s == SEL_W'(i));
            sel_data_s  = (grant_idx_s == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    // Next pointer: one past the winner in round-robin, frozen in fixed mode.
    always_comb begin
        ptr_nxt_s = ptr_r;
        case (mode_e'(fix_en))
            MODE_RR:  ptr_nxt_s = (grant_idx_s == SEL_W'(N_CH - 1)) ? '0 : grant_idx_s + SEL_W'(1);
            MODE_FIX: ptr_nxt_s = ptr_r;
            default:  ptr_nxt_s = ptr_r;
        endcase
    end

    // Output register and pointer; a load without a grant empties the stage but keeps data/ch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            ch_r    <= '0;
            ptr_r   <= '0;
        end else if (fire_s) begin
            valid_r <= 1'b1;
            data_r  <= sel_data_s;
            ch_r    <= grant_idx_s;
            ptr_r   <= ptr_nxt_s;
        end else if (load_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_ch    = ch_r;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench: stimulus queues expected {ch,data} words, monitors pop on each output handshake.
module tb_rr_mux_arb;

    logic        clk;
    logic        rst_n;

    // 4-channel, 4-bit instance
    logic [15:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic        a_fix_en;
    logic [1:0]  a_fix_sel;
    logic [3:0]  a_out_data;
    logic [1:0]  a_out_ch;
    logic        a_out_valid;
    logic        a_out_ready;

    // 3-channel, 8-bit instance
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_fix_en;
    logic [1:0]  b_fix_sel;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_out_ready;

    logic [5:0]  qa[$];
    logic [9:0]  qb[$];
    logic [3:0]  a_forbid;
    int          n_checks;
    int          n_fail;

    rr_mux_arb #(.N_CH(4), .DATA_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .fix_en    (a_fix_en),
        .fix_sel   (a_fix_sel),
        .out_data  (a_out_data),
        .out_ch    (a_out_ch),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    rr_mux_arb #(.N_CH(3), .DATA_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .fix_en    (b_fix_en),
        .fix_sel   (b_fix_sel),
        .out_data  (b_out_data),
        .out_ch    (b_out_ch),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_in_valid  = 4'b0000;
        a_out_ready = 1'b0;
        a_fix_en    = 1'b0;
        a_fix_sel   = 2'd0;
        b_in_valid  = 3'b000;
        b_out_ready = 1'b0;
        b_fix_en    = 1'b0;
        b_fix_sel   = 2'd0;
        a_forbid    = 4'b0000;
        rst_n       = 1'b0;
        #2;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_a_ch", a_out_ch, 0);
        chk("rst_a_ready", a_in_ready, 0);
        chk("rst_b_valid", b_out_valid, 0);
        tick(1);
        rst_n = 1'b1;
    endtask

    // Monitor for the 4-channel instance
    initial begin
        logic [5:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("a_ready_onehot", ($countones(a_in_ready) > 1) ? 1 : 0, 0);
                if (a_forbid != 4'b0000) chk("a_ready_forbidden", a_in_ready & a_forbid, 0);
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL a_unexpected_word: got ch=%0d data=%0h, expected none", a_out_ch, a_out_data);
                    end else begin
                        exp_w = qa.pop_front();
                        chk("a_word", {a_out_ch, a_out_data}, exp_w);
                    end
                end
            end
        end
    end

    // Monitor for the 3-channel instance
    initial begin
        logic [9:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("b_ready_onehot", ($countones(b_in_ready) > 1) ? 1 : 0, 0);
                if (b_out_valid && b_out_ready) begin
                    if (qb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b_unexpected_word: got ch=%0d data=%0h, expected none", b_out_ch, b_out_data);
                    end else begin
                        exp_w = qb.pop_front();
                        chk("b_word", {b_out_ch, b_out_data}, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        a_in_data = 16'hDCBA;
        b_in_data = 24'h332211;
        #1;

        // Round-robin fairness, all channels valid
        do_reset();
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        qa.push_back(6'h0A); qa.push_back(6'h1B); qa.push_back(6'h2C);
        qa.push_back(6'h3D); qa.push_back(6'h0A);
        tick(5);
        a_in_valid = 4'b0000;
        tick(2);

        // Skip and wrap from ptr=1 with channels 0 and 3 valid
        do_reset();
        a_in_valid  = 4'b0001;
        a_out_ready = 1'b1;
        qa.push_back(6'h0A);
        tick(1);
        a_in_valid = 4'b1001;
        a_forbid   = 4'b0110;
        qa.push_back(6'h3D); qa.push_back(6'h0A); qa.push_back(6'h3D);
        tick(3);
        a_in_valid = 4'b0000;
        tick(2);
        a_forbid = 4'b0000;

        // Backpressure: stage holds, no ready, then drain and refill on one edge
        do_reset();
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b0;
        qa.push_back(6'h0A); qa.push_back(6'h1B);
        tick(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_data", a_out_data, 4'hA);
            chk("bp_ch", a_out_ch, 0);
            chk("bp_in_ready", a_in_ready, 0);
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        tick(1);
        a_in_valid = 4'b0000;
        tick(2);

        // Fixed mode on channel 2, then channel 2 drops, then back to round-robin
        do_reset();
        a_fix_en    = 1'b1;
        a_fix_sel   = 2'd2;
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        qa.push_back(6'h2C); qa.push_back(6'h2C); qa.push_back(6'h2C);
        tick(3);
        a_in_valid = 4'b1011;
        tick(1);
        @(negedge clk);
        chk("fix_drop_valid", a_out_valid, 0);
        chk("fix_drop_ready", a_in_ready, 0);
        chk("fix_hold_data", a_out_data, 4'hC);
        chk("fix_hold_ch", a_out_ch, 2);
        @(posedge clk);
        #1;
        a_fix_en = 1'b0;
        qa.push_back(6'h0A);
        tick(1);
        a_in_valid = 4'b0000;
        tick(2);

        // Asynchronous reset while a word is held
        do_reset();
        a_in_valid  = 4'b0010;
        a_out_ready = 1'b0;
        tick(1);
        chk("midrst_pre_valid", a_out_valid, 1);
        chk("midrst_pre_ch", a_out_ch, 1);
        a_in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", a_out_valid, 0);
        chk("midrst_data", a_out_data, 0);
        chk("midrst_ch", a_out_ch, 0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        qa.push_back(6'h0A);
        tick(1);
        a_in_valid = 4'b0000;
        tick(2);

        // Three-channel ring, then out-of-range fixed select
        do_reset();
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;
        qb.push_back(10'h011); qb.push_back(10'h122);
        qb.push_back(10'h233); qb.push_back(10'h011);
        tick(4);
        b_fix_en  = 1'b1;
        b_fix_sel = 2'd3;
        tick(1);
        @(negedge clk);
        chk("b_fix3_valid", b_out_valid, 0);
        chk("b_fix3_ready", b_in_ready, 0);
        @(posedge clk);
        #1;
        b_in_valid = 3'b000;
        b_fix_en   = 1'b0;
        tick(2);

        for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
Parametrised successor of the team's 4x1 4-bit combinational multiplexer. It selects among N_CH input channels of DATA_W bits, either by round-robin arbitration or by a fixed select in legacy mode. Each input channel and the single output use a valid/ready handshake. The output is registered, so downstream logic such as display drivers and ALU operand paths sees stable data, the source channel index and a valid flag.

Parameters:
N_CH, 4, number of input channels (2..16; need not be a power of two)
DATA_W, 4, width of each channel's data word
SEL_W, $clog2(N_CH), width of channel index (derived localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  in  N_CH  per-channel valid
in_ready  out  N_CH  per-channel ready; at most one bit high per cycle
fix_en  in  1  1 = fixed-select mode (legacy mux behaviour), 0 = round-robin
fix_sel  in  SEL_W  channel used when fix_en=1
out_data  out  DATA_W  registered selected data
out_ch  out  SEL_W  index of the channel that produced out_data
out_valid  out  1  out_data/out_ch hold an unconsumed word
out_ready  in  1  downstream accepts the word

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), clock is clk.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready is combinational and therefore 0 while out_valid=0 and no input is valid.
- Load condition: load = ~out_valid | out_ready. The single output register is freed and refilled in the same cycle, giving full throughput.
- Grant, round-robin mode (fix_en=0):
  - Search channels ptr, ptr+1, ..., wrapping modulo N_CH.
  - The first channel with in_valid=1 is granted g.
  - Wrap must be correct for non-power-of-two N_CH; indices >= N_CH are never granted.
- Grant, fixed mode (fix_en=1):
  - g = fix_sel if in_valid[fix_sel]=1, else no grant.
  - If fix_sel >= N_CH, there is no grant.
- in_ready[g] = load & grant_exists; all other in_ready bits are 0. The handshake completes when in_valid[g] & in_ready[g].
- On a clock edge with a completed handshake:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - In round-robin mode, ptr <= (g+1) mod N_CH. In fixed mode, ptr is unchanged.
- On an edge with load=1 and no grant: out_valid <= 0; out_data and out_ch hold their values.
- On an edge with out_valid=1 and out_ready=0: all registers hold and in_ready is all zeros (backpressure).
- Latency: one cycle from input handshake to out_valid.
- Input rules: in_valid must not depend on in_ready; the block must tolerate in_valid dropping without a handshake.
- A mode change (fix_en toggling) takes effect on the next grant decision; a word already held in the output register is unaffected.
- Reset asserted mid-transfer clears the output immediately (asynchronously). The pending word is lost; sources must retry.
- out_ready has a combinational path to in_ready. There is no combinational path from in_data to any output.

Decomposition:
- Shared package/header holds:
  - mode encodings (MODE_RR=0, MODE_FIX=1);
  - a clog2 helper function, if the toolchain lacks $clog2.
- One sub-module is natural: rr_grant. It is combinational, takes valid[N_CH], ptr, fix_en and fix_sel, and returns grant_valid and grant_idx.
- The top level holds ptr, the output register and the ready fan-out.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_ch read 0 immediately, without waiting for a clock edge; after release, the first grant goes to ch0 if valid.
- Round-robin fairness: N_CH=4, all in_valid=1, data ch_i=4'hA+i, out_ready=1 -> out_ch sequence 0,1,2,3,0, out_data A,B,C,D,A on consecutive cycles, one grant per cycle.
- Skip and wrap: in_valid=4'b1001, ptr=1 -> grant ch3, then ch0, then ch3; in_ready never asserted for ch1 or ch2.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0; out_ready=1 -> next word loads on the same edge as the old one is consumed.
- Fixed mode: fix_en=1, fix_sel=2, in_valid=4'b1111 -> only ch2 granted every cycle and ptr unchanged; with fix_sel=2 and in_valid[2]=0 -> out_valid drops to 0.
- Non-power-of-two: N_CH=3, DATA_W=8, all valid -> out_ch sequence 0,1,2,0; index 3 never appears.
